// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   - state_e          : loader FSM states
//   - SYNC_BYTE        : frame start marker
//   - *_DEF            : default geometry of the mem_inst write port
//   - CPU_RST_ACTIVE   : level that holds the pipeline in reset
package program_loader_pkg;

  localparam int unsigned ADDR_W_DEF      = 10;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned ADDR_STRIDE_DEF = 4;
  localparam int unsigned MAX_WORDS_DEF   = 256;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam logic       CPU_RST_ACTIVE = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SYNC   = 4'd1,
    ST_LEN_HI = 4'd2,
    ST_LEN_LO = 4'd3,
    ST_DATA   = 4'd4,
    ST_WRITE  = 4'd5,
    ST_CKSUM  = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and mem_inst write port of the program loader.
//   in_valid/in_byte/in_ready        : host byte source handshake
//   mem_address/mem_data/mem_wren    : mem_inst write port
// slave  = loader side, master = host/memory side.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_address, mem_data, mem_wren
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_address, mem_data, mem_wren
  );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs accepted bytes MSB-first into a 32-bit word.
//   clk_i, rst_ni : clock, async active-low reset
//   byte_i        : incoming byte
//   accept_i      : byte_i is consumed this cycle
//   clear_i       : drop any partial word (has priority over accept_i)
//   word_o        : registered assembled word
//   word_full_o   : this accept completes the 4th byte of a word
module loader_byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  byte_i,
  input  logic        accept_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (accept_i) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = cnt_q + 2'd1;  // wraps to 0 after the 4th byte
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = accept_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream (A5, LEN_HI, LEN_LO,
// 4*N payload bytes MSB-first, XOR checksum), writes each word into
// mem_inst and keeps the pipeline in reset until a frame checks out.
//   clk, rst      : clock, async active-low reset
//   start         : begin a load (honoured in IDLE/DONE/ERR)
//   bus           : byte stream in + mem_inst write port
//   cpu_rst       : active-high pipeline reset, low only in DONE
//   busy          : frame in progress
//   done / error  : outcome of the last load
//   words_written : words written in current/last load
// All outputs come from registers or from a decode of the state register.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_STRIDE = ADDR_STRIDE_DEF,
  parameter int unsigned MAX_WORDS   = MAX_WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  program_loader_if.slave      bus,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_W-1:0]    words_written
);

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        ck_q, ck_d;

  logic        xfer;
  logic        start_ok;
  logic        pk_accept;
  logic        pk_full;
  logic [31:0] pk_word;
  logic [15:0] n_rx;

  assign bus.in_ready = state_q inside {ST_SYNC, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CKSUM};
  assign xfer         = bus.in_valid && bus.in_ready;
  assign start_ok     = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign pk_accept    = xfer && (state_q == ST_DATA);
  assign n_rx         = {len_hi_q, bus.in_byte};

  loader_byte_packer u_packer (
    .clk_i       (clk),
    .rst_ni      (rst),
    .byte_i      (bus.in_byte),
    .accept_i    (pk_accept),
    .clear_i     (start_ok),
    .word_o      (pk_word),
    .word_full_o (pk_full)
  );

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    ck_d     = ck_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok) begin
          state_d  = ST_SYNC;
          len_hi_d = '0;
          len_d    = '0;
          idx_d    = '0;
          addr_d   = '0;
          ck_d     = '0;
        end
      end
      ST_SYNC: begin
        if (xfer && (bus.in_byte == SYNC_BYTE)) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_hi_d = bus.in_byte;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_d = n_rx;
          // Oversized counts are rejected here, before any write, so the
          // address counter can never wrap.
          if (n_rx == 16'd0)                state_d = ST_CKSUM;
          else if (32'(n_rx) > MAX_WORDS)   state_d = ST_ERR;
          else                              state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          ck_d = ck_q ^ bus.in_byte;
          if (pk_full) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d  = idx_q + ADDR_W'(1);
        addr_d = addr_q + ADDR_W'(ADDR_STRIDE);
        if (32'(idx_q) + 32'd1 == 32'(len_q)) state_d = ST_CKSUM;
        else                                  state_d = ST_DATA;
      end
      ST_CKSUM: begin
        if (xfer) state_d = (bus.in_byte == ck_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      len_hi_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      ck_q     <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      ck_q     <= ck_d;
    end
  end

  // addr_q tracks idx_q*ADDR_STRIDE incrementally, so it is valid in WRITE.
  assign bus.mem_wren    = (state_q == ST_WRITE);
  assign bus.mem_address = addr_q;
  assign bus.mem_data    = DATA_W'(pk_word);

  assign cpu_rst       = (state_q == ST_DONE) ? ~CPU_RST_ACTIVE : CPU_RST_ACTIVE;
  assign busy          = state_q inside {ST_SYNC, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_WRITE, ST_CKSUM};
  assign done          = (state_q == ST_DONE);
  assign error         = (state_q == ST_ERR);
  assign words_written = idx_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          cpu_rst, busy, done, error;
  logic [AW-1:0] words_written;

  program_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  program_loader #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .ADDR_STRIDE (4),
    .MAX_WORDS   (256)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .bus           (bus),
    .cpu_rst       (cpu_rst),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  int unsigned   n_tests = 0;
  int unsigned   n_fail = 0;
  int unsigned   n_writes = 0;
  logic [AW-1:0] next_addr = '0;
  logic [7:0]    ck_model = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_wren cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && bus.mem_wren) begin
      n_writes++;
      check_eq("rdy_in_write", 32'(bus.in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("wr_addr", 32'(bus.mem_address), 32'(mon_e.addr));
        check_eq("wr_data", 32'(bus.mem_data), 32'(mon_e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int unsigned t = 0;
    if (gap) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check_eq("ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_byte  = '0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    wr_t e;
    e.addr = next_addr;
    e.data = w;
    exp_q.push_back(e);
    next_addr = next_addr + AW'(4);
    for (int i = 3; i >= 0; i--) begin
      ck_model = ck_model ^ w[i*8 +: 8];
      send_byte(w[i*8 +: 8], gap);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("start_busy",    32'(busy),          32'd1);
    check_eq("start_cpu_rst", 32'(cpu_rst),       32'd1);
    check_eq("start_done",    32'(done),          32'd0);
    check_eq("start_err",     32'(error),         32'd0);
    check_eq("start_ww",      32'(words_written), 32'd0);
    next_addr = '0;
    ck_model  = '0;
  endtask

  task automatic wait_end(input bit exp_done, input int unsigned exp_ww);
    int unsigned t = 0;
    while (!(done || error) && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check_eq("end_done",    32'(done),           32'(exp_done));
    check_eq("end_err",     32'(error),          32'(!exp_done));
    check_eq("end_cpu_rst", 32'(cpu_rst),        32'(!exp_done));
    check_eq("end_busy",    32'(busy),           32'd0);
    check_eq("end_rdy",     32'(bus.in_ready),   32'd0);
    check_eq("end_ww",      32'(words_written),  32'(exp_ww));
    check_eq("end_pending", 32'(exp_q.size()),   32'd0);
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_rdy"},   32'(bus.in_ready),    32'd0);
    check_eq({pfx, "_wren"},  32'(bus.mem_wren),    32'd0);
    check_eq({pfx, "_addr"},  32'(bus.mem_address), 32'd0);
    check_eq({pfx, "_data"},  32'(bus.mem_data),    32'd0);
    check_eq({pfx, "_cpurst"},32'(cpu_rst),         32'd1);
    check_eq({pfx, "_busy"},  32'(busy),            32'd0);
    check_eq({pfx, "_done"},  32'(done),            32'd0);
    check_eq({pfx, "_err"},   32'(error),           32'd0);
    check_eq({pfx, "_ww"},    32'(words_written),   32'd0);
  endtask

  task automatic frame_one(input bit gap);
    send_byte(8'hA5, gap);
    send_byte(8'h00, gap);
    send_byte(8'h01, gap);
    send_word(32'h2008000A, gap);
    send_byte(ck_model, gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = '0;
    #3;
    check_reset_vals("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("idle");

    // 1: single word, good checksum
    pulse_start();
    frame_one(1'b0);
    wait_end(1'b1, 1);

    // 2: two words, bad checksum (correct would be A9)
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(32'h00000020, 1'b0);
    send_word(32'h8C010004, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end(1'b0, 2);

    // 3: garbage before sync, in_valid gapped every other cycle
    pulse_start();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    frame_one(1'b1);
    wait_end(1'b1, 1);

    // 4: N=257 rejected right after LEN_LO
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check_eq("n257_err_now", 32'(error), 32'd1);
    check_eq("n257_cpu_rst", 32'(cpu_rst), 32'd1);
    wait_end(1'b0, 0);

    // 5: empty program, then restart reasserts cpu_rst
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end(1'b1, 0);
    pulse_start();

    // 6: async reset mid-DATA, then a clean load
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h08, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    check_reset_vals("midrst_hold");
    rst = 1'b1;
    pulse_start();
    frame_one(1'b0);
    wait_end(1'b1, 1);

    check_eq("total_writes", 32'(n_writes), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface: accepts a framed byte stream, packs bytes into 32-bit instructions and writes them into mem_inst. The pipeline is the reader of mem_inst.
- Holds the pipeline in reset (cpu_rst) while loading. Releases it only after a complete frame passes its checksum.
- Sits between the host byte source and the mem_inst write port. Drives the pipeline's active-high rst.

Parameters:
ADDR_W, 10, mem_inst address width
DATA_W, 32, instruction width
ADDR_STRIDE, 4, address increment per word (matches fetch stepping PC <= PC + 4)
MAX_WORDS, 256, largest accepted word count (MAX_WORDS*ADDR_STRIDE <= 2^ADDR_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a load; honoured only in IDLE/DONE/ERR
in_valid  in  1  byte source has in_byte
in_byte  in  8  stream byte
in_ready  out  1  loader accepts a byte; transfer when in_valid && in_ready at posedge
mem_address  out  ADDR_W  mem_inst write address
mem_data  out  DATA_W  mem_inst write data
mem_wren  out  1  mem_inst write enable, one cycle per word
cpu_rst  out  1  active-high reset to pipeline
busy  out  1  frame in progress
done  out  1  last load succeeded
error  out  1  last load failed
words_written  out  ADDR_W  words written in current/last load

Behaviour:
- Frame format, in order:
  - SYNC byte 0xA5
  - LEN_HI, LEN_LO: word count N, big-endian
  - 4*N payload bytes, each word MSB first
  - CKSUM: XOR of all payload bytes only
- States: IDLE, SYNC, LEN_HI, LEN_LO, DATA, WRITE, CKSUM, DONE, ERR.
- Reset (rst=0, asynchronous, no clock needed):
  - state IDLE; internal counters, word index and checksum cleared
  - in_ready=0, mem_wren=0, mem_address=0, mem_data=0, cpu_rst=1, busy=0, done=0, error=0, words_written=0
- All outputs are registered or decoded from the state register only; no input-to-output combinational path.
- in_ready=1 exactly in SYNC, LEN_HI, LEN_LO, DATA, CKSUM. It is 0 in IDLE, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start → SYNC. Next cycle: busy=1, done=0, error=0, cpu_rst=1, words_written=0, checksum=0.
- start in any other state is ignored.
- SYNC: accepted 0xA5 → LEN_HI; any other accepted byte is discarded and the state stays SYNC.
- LEN_LO accept → N is complete:
  - N=0 → CKSUM
  - N>MAX_WORDS → ERR, no writes
  - otherwise → DATA
- DATA: shift bytes into the word, MSB first, and XOR each into the checksum. The 4th accepted byte → WRITE.
- WRITE (exactly one cycle):
  - mem_wren=1
  - mem_address = idx*ADDR_STRIDE (truncated to ADDR_W)
  - mem_data = assembled word
  - idx and words_written increment on leaving WRITE
  - → CKSUM if idx+1==N, else DATA
- Write latency: 4th byte accepted at edge t → mem_wren high in the cycle after t. Peak throughput: 4 bytes per 5 cycles.
- CKSUM: the accepted byte is compared with the accumulated XOR.
  - match → DONE
  - mismatch → ERR
- DONE: done=1, busy=0, cpu_rst=0. Holds until start.
- ERR: error=1, busy=0, cpu_rst=1. Holds until start.
- cpu_rst deasserts only on entry to DONE. It reasserts in the cycle following an accepted start.
- Gaps in in_valid are allowed anywhere; state and partial word are held.
- Reset mid-frame:
  - immediate return to reset values
  - words already written remain in mem_inst
  - no mem_wren glitch
- No address wrap is possible: N<=MAX_WORDS is enforced before any write.

Decomposition:
- Shared package holds:
  - state encoding (4-bit localparams)
  - SYNC_BYTE=8'hA5
  - default ADDR_W/DATA_W/ADDR_STRIDE/MAX_WORDS
  - pipeline reset polarity constant
- One sub-module: loader_byte_packer.
  - Inputs: byte, accept strobe, clear.
  - Behaviour: shifts bytes MSB-first into a 32-bit word and keeps a 2-bit byte count.
  - Outputs: word and a word_full flag.
- FSM, address/index counters and checksum stay in program_loader.

Test Plan:
- Reset, start, stream A5 00 01 20 08 00 0A 22 → one write: addr 0, data 0x2008000A. Then done=1, error=0, cpu_rst=0, words_written=1.
- Stream A5 00 02 + words 0x00000020, 0x8C010004 + checksum 0x00 (correct is 0xA9) → writes at addr 0 and 4, then error=1, cpu_rst=1, done=0.
- Garbage 00 FF 5A before A5 with in_valid deasserted every other cycle → garbage discarded, same result as scenario 1. in_ready=0 during the WRITE cycle.
- Stream A5 01 01 (N=257) → ERR right after LEN_LO, mem_wren never asserted, cpu_rst=1.
- Stream A5 00 00 00 → DONE with zero writes, cpu_rst=0. A second start reasserts cpu_rst=1 the next cycle.
- rst=0 mid-DATA between clock edges → all outputs at reset values immediately. After rst=1, a start plus the scenario 1 frame completes with done=1.
